// File: rtl/operand_loader_pkg.sv
// -----------------------------------------------------------------------------
// operand_loader_pkg
// Shared types and constants for the operand_loader front-end sequencer.
//   DATA_W   : operand width driven to the add/sub display unit.
//   state_t  : entry FSM state. The encoding is visible on state_led.
//   op_regs_t: the registered outputs, grouped so they can be cleared together.
// -----------------------------------------------------------------------------
package operand_loader_pkg;

   localparam int DATA_W = 4;

   typedef enum logic [1:0] {
      LOAD_A  = 2'b00,
      LOAD_B  = 2'b01,
      LOAD_OP = 2'b10,
      SHOW    = 2'b11
   } state_t;

   typedef struct packed {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic              sel;   // 0 = add, 1 = subtract
      logic              en;
   } op_regs_t;

endpackage

// File: rtl/operand_loader_btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Conditions one raw push-button: a 2-flop synchroniser, a stability counter
// and a rising-edge pulse generator.
//   clk       : system clock, rising edge
//   rst_n     : synchronous reset, active low
//   btn_raw   : raw, bouncing, active-high button
//   btn_level : accepted (debounced) level
//   btn_pulse : one-cycle pulse on each accepted 0->1 transition
// The accepted level flips only after the synchronised level has differed from
// it for DEBOUNCE_CYCLES consecutive cycles. Any shorter excursion restarts
// the count.
// -----------------------------------------------------------------------------
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 2_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic btn_level,
   output logic btn_pulse
);

   localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0]  CNT_TOP = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync2_q;
   logic             level_q, level_d;
   logic             level_prev_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // The counter only runs while the levels disagree. When the last count is
   // reached the level flips and the counter falls back to zero, ready for the
   // opposite transition.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_TOP) begin
            level_d = ~level_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // The synchroniser is reset too. This forces a button held through reset to
   // be re-qualified from scratch.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         level_q      <= 1'b0;
         level_prev_q <= 1'b0;
         cnt_q        <= '0;
      end else begin
         sync1_q      <= btn_raw;
         sync2_q      <= sync1_q;
         level_q      <= level_d;
         level_prev_q <= level_q;
         cnt_q        <= cnt_d;
      end
   end

   assign btn_level = level_q;
   assign btn_pulse = level_q & ~level_prev_q;

endmodule

// File: rtl/operand_loader.sv
// -----------------------------------------------------------------------------
// operand_loader
// Steps the user through entry of operand A, operand B and the operation, using
// the slide switches and two debounced buttons. It drives the registered
// control and data inputs of the add/sub display unit.
//   clk       : system clock, rising edge
//   rst_n     : synchronous reset, active low
//   sw        : raw slide switches (quasi-static, not synchronised)
//   btn_next  : raw "advance" button, active high
//   btn_clr   : raw "clear" button, active high
//   en        : arithmetic enable, high only in SHOW
//   mux_sel   : 0 = add, 1 = subtract
//   input_a   : operand A
//   input_b   : operand B
//   state_led : current FSM state encoding
// Build option OPERAND_LOADER_LIVE_OP_EN: while in SHOW, mux_sel tracks sw[0]
// every cycle, with one register of latency.
// -----------------------------------------------------------------------------
module operand_loader
   import operand_loader_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 2_000_000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] sw,
   input  logic              btn_next,
   input  logic              btn_clr,
   output logic              en,
   output logic              mux_sel,
   output logic [DATA_W-1:0] input_a,
   output logic [DATA_W-1:0] input_b,
   output logic [1:0]        state_led
);

   logic     next_p, clr_p;
   logic     next_lvl, clr_lvl;
   state_t   state_q, state_d;
   op_regs_t regs_q, regs_d;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next_db (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_raw   (btn_next),
      .btn_level (next_lvl),
      .btn_pulse (next_p)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr_db (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_raw   (btn_clr),
      .btn_level (clr_lvl),
      .btn_pulse (clr_p)
   );

   // The debounced levels are not needed by the sequencer, which acts on the
   // pulses only.
   logic unused_lvl;
   assign unused_lvl = next_lvl ^ clr_lvl;

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= LOAD_A;
      else        state_q <= state_d;
   end

   // ---------------- next state ----------------
   // Clear takes priority. A coincident advance pulse is dropped.
   always_comb begin
      state_d = state_q;
      if (clr_p) begin
         state_d = LOAD_A;
      end else if (next_p) begin
         case (state_q)
            LOAD_A:  state_d = LOAD_B;
            LOAD_B:  state_d = LOAD_OP;
            LOAD_OP: state_d = SHOW;
            SHOW:    state_d = LOAD_A;
            default: state_d = LOAD_A;
         endcase
      end
   end

   // ---------------- output register update ----------------
   // sw is sampled directly on the update edge.
   always_comb begin
      regs_d = regs_q;
`ifdef OPERAND_LOADER_LIVE_OP_EN
      // Live operation select while results are displayed. The value sampled
      // on the edge that leaves SHOW is the one that stays frozen.
      if (state_q == SHOW) regs_d.sel = sw[0];
`endif
      if (clr_p) begin
         regs_d = '0;
      end else if (next_p) begin
         case (state_q)
            LOAD_A:  regs_d.a = sw;
            LOAD_B:  regs_d.b = sw;
            LOAD_OP: begin
               regs_d.sel = sw[0];
               regs_d.en  = 1'b1;
            end
            SHOW:    regs_d.en = 1'b0;
            default: regs_d = regs_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) regs_q <= '0;
      else        regs_q <= regs_d;
   end

   assign en        = regs_q.en;
   assign mux_sel   = regs_q.sel;
   assign input_a   = regs_q.a;
   assign input_b   = regs_q.b;
   assign state_led = state_q;

endmodule
